// File: rtl/div_16x8_seq_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : div_pkg
// Purpose  : Shared constants and FSM state type for the 16x8 sequential
//            restoring divider.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
package div_pkg;

   // Default operand widths: 16-bit dividend/quotient, 8-bit divisor/remainder
   localparam int c_DW = 16;
   localparam int c_VW = 8;

   // Iteration counter width, wide enough to count DW-1 down to zero
   localparam int c_CW = $clog2(c_DW);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage : div_pkg
`default_nettype wire

// File: rtl/div_16x8_seq_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : div_16x8_seq_if
// Purpose  : Operand and result handshake bundle for the sequential divider.
//            master = producer/consumer side, slave = divider side.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
interface div_16x8_seq_if
   import div_pkg::*;
#(
   parameter int DW = c_DW,
   parameter int VW = c_VW
);

   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] dividend;
   logic [VW-1:0] divisor;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] quotient;
   logic [VW-1:0] remainder;
   logic          div_by_zero;

   modport master (
      output in_valid, dividend, divisor, out_ready,
      input  in_ready, out_valid, quotient, remainder, div_by_zero
   );

   modport slave (
      input  in_valid, dividend, divisor, out_ready,
      output in_ready, out_valid, quotient, remainder, div_by_zero
   );

endinterface : div_16x8_seq_if
`default_nettype wire

// File: rtl/div_16x8_seq_step.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : div_step
// Purpose  : One restoring-division iteration: shift the next dividend bit
//            into the partial remainder, trial-subtract the divisor and keep
//            the difference only when it does not borrow.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module div_step
#(
   parameter int VW = 8
)
(
   input  wire logic [VW:0]   rem_in,
   input  wire logic          bit_in,
   input  wire logic [VW-1:0] divisor,
   output logic      [VW:0]   rem_out,
   output logic               q_bit
);

   logic [VW:0] w_shift;
   logic [VW:0] w_diff;
   logic        w_no_borrow;

   // Shift-and-trial-subtract. The bit shifted out of rem_in is zero whenever
   // rem_in < divisor; it is still folded into the compare so that a set bit
   // (true value >= 2^(VW+1)) always counts as "no borrow".
   always_comb begin
      w_shift     = {rem_in[VW-1:0], bit_in};
      w_diff      = w_shift - {1'b0, divisor};
      w_no_borrow = rem_in[VW] | (w_shift >= {1'b0, divisor});
      q_bit       = w_no_borrow;
      rem_out     = w_no_borrow ? w_diff : w_shift;
   end

endmodule : div_step
`default_nettype wire

// File: rtl/div_16x8_seq.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : div_16x8_seq
// Purpose  : Sequential unsigned DW-by-VW restoring divider, one quotient bit
//            per clock, valid/ready on both input and output. A zero divisor
//            short-circuits to an all-ones quotient with div_by_zero set.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module div_16x8_seq
   import div_pkg::*;
#(
   parameter int DW = c_DW,
   parameter int VW = c_VW
)
(
   input  wire logic     clk,
   input  wire logic     rst,
   div_16x8_seq_if.slave bus
);

   localparam int CW = $clog2(DW);

   state_t        r_state;
   state_t        w_next;

   logic [VW:0]   r_prem;      // partial remainder, one guard bit
   logic [DW-1:0] r_shift;     // dividend bits out of the MSB, quotient in at LSB
   logic [VW-1:0] r_div;
   logic [CW-1:0] r_cnt;

   logic [DW-1:0] r_quot;
   logic [VW-1:0] r_rem;
   logic          r_dbz;

   logic          w_accept;
   logic          w_div_zero;
   logic          w_last;
   logic [VW:0]   w_prem_next;
   logic          w_qbit;

   div_step #(.VW(VW)) u_step (
      .rem_in  (r_prem),
      .bit_in  (r_shift[DW-1]),
      .divisor (r_div),
      .rem_out (w_prem_next),
      .q_bit   (w_qbit)
   );

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state decode and handshake outputs
   always_comb begin
      w_next        = r_state;
      w_accept      = 1'b0;
      w_last        = 1'b0;
      w_div_zero    = (bus.divisor == '0);
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      case (r_state)
         IDLE: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) begin
               w_accept = 1'b1;
               w_next   = w_div_zero ? DONE : CALC;
            end
         end
         CALC: begin
            if (r_cnt == '0) begin
               w_last = 1'b1;
               w_next = DONE;
            end
         end
         DONE: begin
            bus.out_valid = 1'b1;
            if (bus.out_ready) begin
               w_next = IDLE;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   // Operand latch, iteration datapath and result registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_prem  <= '0;
         r_shift <= '0;
         r_div   <= '0;
         r_cnt   <= '0;
         r_quot  <= '0;
         r_rem   <= '0;
         r_dbz   <= 1'b0;
      end else if (w_accept) begin
         r_prem  <= '0;
         r_shift <= bus.dividend;
         r_div   <= bus.divisor;
         r_cnt   <= CW'(DW - 1);
         if (w_div_zero) begin
            r_quot <= '1;
            r_rem  <= bus.dividend[VW-1:0];
            r_dbz  <= 1'b1;
         end
      end else if (r_state == CALC) begin
         r_prem  <= w_prem_next;
         r_shift <= {r_shift[DW-2:0], w_qbit};
         r_cnt   <= r_cnt - 1'b1;
         if (w_last) begin
            r_quot <= {r_shift[DW-2:0], w_qbit};
            r_rem  <= w_prem_next[VW-1:0];
            r_dbz  <= 1'b0;
         end
      end
   end

   assign bus.quotient    = r_quot;
   assign bus.remainder   = r_rem;
   assign bus.div_by_zero = r_dbz;

endmodule : div_16x8_seq
`default_nettype wire

// File: tb/tb_div_16x8_seq.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_div_16x8_seq
// Purpose  : Scoreboard bench for the sequential divider: directed vectors,
//            backpressure, mid-operation reset and a random sweep.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_div_16x8_seq;
   import div_pkg::*;

   typedef struct packed {
      logic [15:0] q;
      logic [7:0]  r;
      logic        z;
   } exp_t;

   typedef struct packed {
      logic [15:0] a;
      logic [7:0]  b;
      logic [15:0] q;
      logic [7:0]  r;
      logic        z;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests = 0;
   int   fails = 0;
   int   mode  = 0;    // consumer: 0 always ready, 1 stalled, 2 random
   exp_t sb[$];

   div_16x8_seq_if #(.DW(16), .VW(8)) bus ();

   div_16x8_seq #(.DW(16), .VW(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Free-running clock
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      tests++;
      if (act !== expv) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, expv, $time);
      end
   endtask

   // Consumer: drives out_ready once per cycle according to the current mode
   initial begin
      bus.out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         case (mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = 1'b0;
            default: bus.out_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Monitor: every output handshake pops and compares one expected result
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_result: got q=%0h r=%0h, expected no result", bus.quotient, bus.remainder);
            end else begin
               e = sb.pop_front();
               check("quotient",    32'(bus.quotient),    32'(e.q));
               check("remainder",   32'(bus.remainder),   32'(e.r));
               check("div_by_zero", 32'(bus.div_by_zero), 32'(e.z));
            end
         end
      end
   end

   // Present one operand pair, push its expected result, return just after the accept edge
   task automatic send(input logic [15:0] a, input logic [7:0] b,
                       input logic [15:0] q, input logic [7:0] r, input logic z);
      int n;
      exp_t e;
      n = 0;
      @(negedge clk);
      while (!bus.in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!bus.in_ready) begin
         check("in_ready_timeout", 32'(bus.in_ready), 32'd1);
         return;
      end
      e.q = q; e.r = r; e.z = z;
      sb.push_back(e);
      bus.in_valid = 1'b1;
      bus.dividend = a;
      bus.divisor  = b;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.dividend = 16'($urandom);
      bus.divisor  = 8'($urandom);
   endtask

   // Edges after the accept edge until out_valid is seen
   task automatic wait_valid(output int n);
      n = 0;
      while (!bus.out_valid && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (!bus.out_valid) check("out_valid_timeout", 32'(bus.out_valid), 32'd1);
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 400) begin
         @(posedge clk);
         n++;
      end
      if (sb.size() != 0) check("drain_timeout", 32'(sb.size()), 32'd0);
   endtask

   // Hard time limit
   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Stimulus
   initial begin
      vec_t vecs[6];
      int   lat;
      logic [15:0] ra;
      logic [7:0]  rb;

      vecs[0] = '{a: 16'd1000,  b: 8'd7,   q: 16'd142,   r: 8'd6,    z: 1'b0};
      vecs[1] = '{a: 16'd65535, b: 8'd1,   q: 16'd65535, r: 8'd0,    z: 1'b0};
      vecs[2] = '{a: 16'd65025, b: 8'd255, q: 16'd255,   r: 8'd0,    z: 1'b0};
      vecs[3] = '{a: 16'd0,     b: 8'd9,   q: 16'd0,     r: 8'd0,    z: 1'b0};
      vecs[4] = '{a: 16'd7,     b: 8'd200, q: 16'd0,     r: 8'd7,    z: 1'b0};
      vecs[5] = '{a: 16'd5,     b: 8'd0,   q: 16'hFFFF,  r: 8'h05,   z: 1'b1};

      bus.in_valid = 1'b0;
      bus.dividend = '0;
      bus.divisor  = '0;

      // Reset values
      #12;
      check("rst_out_valid",   32'(bus.out_valid),   32'd0);
      check("rst_quotient",    32'(bus.quotient),    32'd0);
      check("rst_remainder",   32'(bus.remainder),   32'd0);
      check("rst_div_by_zero", 32'(bus.div_by_zero), 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      check("rst_in_ready", 32'(bus.in_ready), 32'd1);

      // Directed vectors with latency checks
      foreach (vecs[i]) begin
         send(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].z);
         wait_valid(lat);
         if (vecs[i].z) check("latency_div0", 32'(lat), 32'd0);
         else           check("latency_calc", 32'(lat), 32'd16);
         wait_drain();
      end

      // Backpressure: result must hold, in_valid pulses must be ignored
      mode = 1;
      @(posedge clk);
      #3;
      send(16'd1000, 8'd7, 16'd142, 8'd6, 1'b0);
      wait_valid(lat);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("stall_quotient",  32'(bus.quotient),  32'd142);
         check("stall_remainder", 32'(bus.remainder), 32'd6);
         check("stall_in_ready",  32'(bus.in_ready),  32'd0);
         check("stall_out_valid", 32'(bus.out_valid), 32'd1);
         bus.in_valid = (i % 2 == 0);
         bus.dividend = 16'd9;
         bus.divisor  = 8'd3;
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      mode = 0;
      @(posedge clk);
      #3;
      check("release_still_valid", 32'(bus.out_valid), 32'd1);
      @(posedge clk);
      #1;
      check("release_out_valid", 32'(bus.out_valid), 32'd0);
      check("release_in_ready",  32'(bus.in_ready),  32'd1);
      send(16'd300, 8'd3, 16'd100, 8'd0, 1'b0);
      wait_drain();

      // Reset in the middle of a calculation
      send(16'd1000, 8'd7, 16'd142, 8'd6, 1'b0);
      repeat (8) @(posedge clk);
      #1 rst = 1'b1;
      sb.delete();
      #1;
      check("abort_out_valid", 32'(bus.out_valid), 32'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      check("abort_in_ready", 32'(bus.in_ready), 32'd1);
      check("abort_quotient", 32'(bus.quotient), 32'd0);
      repeat (20) @(posedge clk);
      #1;
      check("abort_no_result", 32'(bus.out_valid), 32'd0);
      send(16'd50, 8'd6, 16'd8, 8'd2, 1'b0);
      wait_drain();

      // Random operands with random consumer stalls
      mode = 2;
      for (int i = 0; i < 600; i++) begin
         ra = 16'($urandom);
         rb = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom);
         if (rb == 8'd0) send(ra, rb, 16'hFFFF, ra[7:0], 1'b1);
         else            send(ra, rb, ra / 16'(rb), 8'(ra % 16'(rb)), 1'b0);
      end
      wait_drain();
      mode = 0;
      repeat (3) @(posedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule : tb_div_16x8_seq
`default_nettype wire
